// File: rtl/cmd_saver_if.sv
// Control, RAM read port and output byte-stream signals of the /CMD image serialiser.
// master is the serialiser side; slave is the CPU/RAM/upload-sink side.
interface cmd_saver_if;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic [15:0] exec_addr;
  logic        busy;
  logic        done;
  logic [16:0] file_size;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    input  start, start_addr, end_addr, exec_addr, mem_data, out_ready,
    output busy, done, file_size, mem_rd, mem_addr, out_data, out_valid
  );

  modport slave (
    output start, start_addr, end_addr, exec_addr, mem_data, out_ready,
    input  busy, done, file_size, mem_rd, mem_addr, out_data, out_valid
  );
endinterface

// File: rtl/cmd_saver.sv
// Serialises a RAM region into a TRS-80 /CMD image: load records of up to
// MAX_BLOCK bytes followed by one transfer record carrying the entry address.
module cmd_saver #(
  parameter int MAX_BLOCK = 256
) (
  input logic         clock,
  input logic         reset_n,
  cmd_saver_if.master bus
);

  // state  | meaning
  // IDLE   | wait for start       H_*   | load-record header bytes (type, len, addr lo/hi)
  // FETCH  | RAM read strobe      WAIT  | RAM data arrives, loaded into out_data
  // DATA   | present data byte    X_*   | transfer record (type, len, exec lo/hi)
  // DONE   | done pulse, busy drops
  typedef enum logic [3:0] {
    IDLE, H_TYPE, H_LEN, H_ALO, H_AHI, FETCH, WAIT, DATA,
    X_TYPE, X_LEN, X_LO, X_HI, DONE
  } state_t;

  localparam logic [16:0] MAXB = 17'(MAX_BLOCK);

  state_t      state_q;
  logic [16:0] addr_q;
  logic [16:0] rem_q;
  logic [16:0] rec_rem_q;
  logic [15:0] exec_q;
  logic [16:0] file_size_q;
  logic        busy_q;
  logic        done_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        mem_rd_q;
  logic [15:0] mem_addr_q;

  logic [16:0] n_d;
  logic [17:0] r_num_d;
  logic [16:0] r_d;
  logic [16:0] fs_d;
  logic [16:0] blk_cnt_d;
  logic [16:0] blk_len_d;
  logic        hs;

  always_comb begin
    n_d = 17'd0;
    if (bus.start_addr <= bus.end_addr)
      n_d = {1'b0, bus.end_addr} - {1'b0, bus.start_addr} + 17'd1;
    r_num_d   = {1'b0, n_d} + 18'(MAX_BLOCK - 1);
    r_d       = 17'(r_num_d / 18'(MAX_BLOCK));
    fs_d      = n_d + {r_d[14:0], 2'b00} + 17'd4;
    blk_cnt_d = (rem_q > MAXB) ? MAXB : rem_q;
    blk_len_d = blk_cnt_d + 17'd2;
  end

  assign hs = out_valid_q & bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      rec_rem_q   <= '0;
      exec_q      <= '0;
      file_size_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_q      <= {1'b0, bus.start_addr};
            rem_q       <= n_d;
            exec_q      <= bus.exec_addr;
            file_size_q <= fs_d;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            if (n_d == 17'd0) begin
              out_data_q <= 8'h02;
              state_q    <= X_TYPE;
            end else begin
              out_data_q <= 8'h01;
              state_q    <= H_TYPE;
            end
          end
        end
        H_TYPE: if (hs) begin
          out_data_q <= blk_len_d[7:0];
          rec_rem_q  <= blk_cnt_d;
          state_q    <= H_LEN;
        end
        H_LEN: if (hs) begin
          out_data_q <= addr_q[7:0];
          state_q    <= H_ALO;
        end
        H_ALO: if (hs) begin
          out_data_q <= addr_q[15:8];
          state_q    <= H_AHI;
        end
        H_AHI: if (hs) begin
          out_valid_q <= 1'b0;
          mem_rd_q    <= 1'b1;
          mem_addr_q  <= addr_q[15:0];
          state_q     <= FETCH;
        end
        FETCH: begin
          mem_rd_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: begin
          // counters advance here so DATA can decide the next record directly
          out_data_q  <= bus.mem_data;
          out_valid_q <= 1'b1;
          addr_q      <= addr_q + 17'd1;
          rem_q       <= rem_q - 17'd1;
          rec_rem_q   <= rec_rem_q - 17'd1;
          state_q     <= DATA;
        end
        DATA: if (hs) begin
          if (rec_rem_q != 17'd0) begin
            out_valid_q <= 1'b0;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= addr_q[15:0];
            state_q     <= FETCH;
          end else if (rem_q != 17'd0) begin
            out_data_q <= 8'h01;
            state_q    <= H_TYPE;
          end else begin
            out_data_q <= 8'h02;
            state_q    <= X_TYPE;
          end
        end
        X_TYPE: if (hs) begin
          out_data_q <= 8'h02;
          state_q    <= X_LEN;
        end
        X_LEN: if (hs) begin
          out_data_q <= exec_q[7:0];
          state_q    <= X_LO;
        end
        X_LO: if (hs) begin
          out_data_q <= exec_q[15:8];
          state_q    <= X_HI;
        end
        X_HI: if (hs) begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.file_size = file_size_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule
